// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, schedule geometry lookup,
// GF(2^8) xtime and the key schedule state enumeration.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_LEN_128  = 2'd0,
    KEY_LEN_192  = 2'd1,
    KEY_LEN_256  = 2'd2,
    KEY_LEN_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    LAST = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] nk;
    logic [3:0] nr;
  } key_geom_t;

  // Nk = 0 marks the reserved encoding so callers can reject it.
  function automatic key_geom_t key_geom(input logic [1:0] key_len);
    key_geom_t g;
    case (key_len_e'(key_len))
      KEY_LEN_128: begin g.nk = 4'd4; g.nr = 4'd10; end
      KEY_LEN_192: begin g.nk = 4'd6; g.nr = 4'd12; end
      KEY_LEN_256: begin g.nk = 4'd8; g.nr = 4'd14; end
      default:     begin g.nk = 4'd0; g.nr = 4'd0;  end
    endcase
    return g;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_byte.sv
// AES forward S-box, one byte, purely combinational table lookup.
module sub_byte (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_word.sv
// 32-bit SubWord: four independent S-box lookups, one per byte lane.
module sub_word (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    sub_byte u_sub_byte (
      .in_byte  (in_word[8*b +: 8]),
      .out_byte (out_word[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Word-serial AES-128/192/256 key schedule: one expanded word per cycle,
// grouped into 128-bit round keys delivered over a valid/ready output register.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int NK_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);

  localparam logic [3:0] NK_LIMIT = 4'(NK_MAX);

  state_e        state_q, state_d;
  logic [5:0]    widx_q, widx_d;
  logic [2:0]    phase_q, phase_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    nk_q, nk_d;
  logic [3:0]    nr_q, nr_d;
  logic [31:0]   key_q [8];
  logic [31:0]   key_d [8];
  logic [31:0]   hist_q [8];
  logic [31:0]   hist_d [8];
  logic [31:0]   grp_q [3];
  logic [31:0]   grp_d [3];
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          rk_valid_q, rk_valid_d;
  logic [127:0]  rk_data_q, rk_data_d;
  logic [3:0]    rk_idx_q, rk_idx_d;
  logic          done_q, done_d;

  key_geom_t     geom_s;
  logic          hs_s, gen_en_s, from_key_s;
  logic [31:0]   prev_s, back_s, sw_in_s, sw_out_s, word_s;

  sub_word u_sub_word (
    .in_word  (sw_in_s),
    .out_word (sw_out_s)
  );

  // Word datapath: hist_q[0] is w[i-1], hist_q[j] is w[i-1-j]; phase_q is i mod Nk.
  always_comb begin
    prev_s     = hist_q[0];
    from_key_s = ({2'b00, nk_q} > widx_q);
    case (nk_q)
      4'd4:    back_s = hist_q[3];
      4'd6:    back_s = hist_q[5];
      default: back_s = hist_q[7];
    endcase
    if (phase_q == 3'd0) begin
      sw_in_s = {prev_s[23:0], prev_s[31:24]};
    end else begin
      sw_in_s = prev_s;
    end
    if (from_key_s) begin
      word_s = key_q[widx_q[2:0]];
    end else if (phase_q == 3'd0) begin
      word_s = back_s ^ sw_out_s ^ {rcon_q, 24'h000000};
    end else if ((nk_q == 4'd8) && (phase_q == 3'd4)) begin
      word_s = back_s ^ sw_out_s;
    end else begin
      word_s = back_s ^ prev_s;
    end
  end

  // Control: start acceptance, generation with group-completion stall, output handshake.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    phase_d    = phase_q;
    rcon_d     = rcon_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    key_d      = key_q;
    hist_d     = hist_q;
    grp_d      = grp_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rk_data_d  = rk_data_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;
    geom_s     = key_geom(key_len);
    hs_s       = rk_valid_q & rk_ready;
    // The group-closing word may only be produced if the output register can take it.
    gen_en_s   = (state_q == GEN) &&
                 ((widx_q[1:0] != 2'b11) || !rk_valid_q || rk_ready);
    if (hs_s) begin
      rk_valid_d = 1'b0;
    end else begin
      rk_valid_d = rk_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((geom_s.nk == 4'd0) || (geom_s.nk > NK_LIMIT)) begin
            err_d = 1'b1;
          end else begin
            state_d = GEN;
            busy_d  = 1'b1;
            nk_d    = geom_s.nk;
            nr_d    = geom_s.nr;
            widx_d  = 6'd0;
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            for (int j = 0; j < 8; j++) begin
              key_d[j] = key_in[32*(7-j) +: 32];
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      GEN: begin
        if (gen_en_s) begin
          hist_d[0] = word_s;
          for (int j = 1; j < 8; j++) begin
            hist_d[j] = hist_q[j-1];
          end
          if ({1'b0, phase_q} == (nk_q - 4'd1)) begin
            phase_d = 3'd0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
          if (!from_key_s && (phase_q == 3'd0)) begin
            rcon_d = xtime(rcon_q);
          end else begin
            rcon_d = rcon_q;
          end
          case (widx_q[1:0])
            2'd0: grp_d[0] = word_s;
            2'd1: grp_d[1] = word_s;
            2'd2: grp_d[2] = word_s;
            default: begin
              rk_data_d  = {grp_q[0], grp_q[1], grp_q[2], word_s};
              rk_valid_d = 1'b1;
              rk_idx_d   = widx_q[5:2];
            end
          endcase
          // Last word index is 4*(Nr+1)-1 = {Nr, 2'b11}.
          if (widx_q == {nr_q, 2'b11}) begin
            state_d = LAST;
          end else begin
            widx_d  = widx_q + 6'd1;
            state_d = GEN;
          end
        end else begin
          state_d = GEN;
        end
      end
      LAST: begin
        if (hs_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = LAST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      widx_q     <= 6'd0;
      phase_q    <= 3'd0;
      rcon_q     <= 8'h01;
      nk_q       <= 4'd0;
      nr_q       <= 4'd0;
      for (int j = 0; j < 8; j++) begin
        key_q[j]  <= 32'h00000000;
        hist_q[j] <= 32'h00000000;
      end
      for (int j = 0; j < 3; j++) begin
        grp_q[j] <= 32'h00000000;
      end
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= 128'h0;
      rk_idx_q   <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      phase_q    <= phase_d;
      rcon_q     <= rcon_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      key_q      <= key_d;
      hist_q     <= hist_d;
      grp_q      <= grp_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Bench for aes_key_schedule_seq: FIPS-197 vectors, random keys and random
// backpressure against an array-based key expansion model.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst, start, start4, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, done;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy4, err4, rk_valid4, done4;
  logic [127:0] rk_data4;
  logic [3:0]   rk_idx4;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.NK_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .done(done)
  );

  aes_key_schedule_seq #(.NK_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_len(key_len), .key_in(key_in),
    .busy(busy4), .err(err4), .rk_valid(rk_valid4), .rk_ready(rk_ready),
    .rk_data(rk_data4), .rk_idx(rk_idx4), .done(done4)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Textbook expansion into a word array; fills exp_rk, returns Nr.
  function automatic int model(input logic [255:0] key, input logic [1:0] kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = 4 + 2 * int'(kl);
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return nr;
  endfunction

  task automatic run_sched(input logic [1:0] kl, input logic [255:0] key, input bit rand_rdy,
                           input int abort_at, input bit kat_en, input logic [127:0] kat);
    int nr = model(key, kl);
    int got = 0;
    int first_v = -1;
    int last_cyc = -1;
    int done_cnt = 0;
    bit prev_stall = 1'b0;
    logic [127:0] prev_data = 128'h0;
    logic [3:0]   prev_idx = 4'd0;
    logic [127:0] last_key = 128'h0;
    @(negedge clk);
    start = 1'b1; key_len = kl; key_in = key; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1'b1);
    for (int cyc = 0; cyc < 3000 && got <= nr; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!rand_rdy && abort_at < 0 && cyc == 7) begin
        start = 1'b1; key_len = 2'd3;
      end
      if (!rand_rdy && abort_at < 0 && cyc == 8) begin
        start = 1'b0; key_len = kl;
        check_val("start_while_busy_err", err, 1'b0);
        check_val("start_while_busy_busy", busy, 1'b1);
      end
      rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) begin
        check_val("stall_data_stable", rk_data, prev_data);
        check_val("stall_idx_stable", rk_idx, prev_idx);
      end
      done_cnt += int'(done);
      if (rk_valid && first_v < 0) first_v = cyc;
      if (abort_at >= 0 && rk_valid && int'(rk_idx) == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_val("abort_outputs", {busy, err, rk_valid, done, rk_idx, rk_data}, 256'h0);
        rst = 1'b0;
        return;
      end
      if (rk_valid && rk_ready) begin
        check_val($sformatf("rk_data_%0d", got), rk_data, exp_rk[got]);
        check_val($sformatf("rk_idx_%0d", got), rk_idx, got);
        last_key = rk_data;
        got++;
        last_cyc = cyc;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_data  = rk_data;
      prev_idx   = rk_idx;
    end
    check_val("key_count", got, nr + 1);
    check_val("no_early_done", done_cnt, 0);
    if (kat_en) check_val("kat_last_key", last_key, kat);
    if (!rand_rdy) begin
      check_val("first_valid_latency", first_v, 4);
      check_val("last_key_cycle", last_cyc, 4 * (nr + 1));
    end
    @(negedge clk);
    check_val("done_pulse", done, 1'b1);
    check_val("busy_fall", busy, 1'b0);
    check_val("valid_after_last", rk_valid, 1'b0);
    @(negedge clk);
    check_val("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    logic [255:0] k128, k192, k256, rk;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; rk_ready = 1'b0;
    key_len = 2'd0; key_in = 256'h0;
    build_sbox();
    repeat (3) @(negedge clk);
    check_val("reset_outputs", {busy, err, rk_valid, done, rk_idx, rk_data}, 256'h0);
    check_val("reset_outputs4", {busy4, err4, rk_valid4, done4, rk_idx4, rk_data4}, 256'h0);
    rst = 1'b0;

    run_sched(2'd0, k128, 1'b0, -1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_sched(2'd1, k192, 1'b0, -1, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    run_sched(2'd2, k256, 1'b0, -1, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);
    run_sched(2'd2, k256, 1'b1, -1, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e);

    @(negedge clk);
    start = 1'b1; key_len = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check_val("rsvd_err", err, 1'b1);
    check_val("rsvd_busy", busy, 1'b0);
    @(negedge clk);
    check_val("rsvd_err_clear", err, 1'b0);
    check_val("rsvd_busy_idle", busy, 1'b0);

    start4 = 1'b1; key_len = 2'd2;
    @(negedge clk);
    start4 = 1'b0;
    check_val("nkmax_err", err4, 1'b1);
    check_val("nkmax_busy", busy4, 1'b0);
    @(negedge clk);
    check_val("nkmax_err_clear", err4, 1'b0);

    run_sched(2'd0, k128, 1'b0, 5, 1'b0, 128'h0);
    run_sched(2'd0, k128, 1'b0, -1, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
      run_sched(2'($urandom_range(0, 2)), rk, 1'b1, -1, 1'b0, 128'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
